// File: rtl/instbuffer_ctrl.sv
// Occupancy and flow controller for the dual-issue instruction FIFO between if_unit and if_id.
// Optional perf counters are built only when INSTBUF_PERF_CNT_EN is defined.
module instbuffer_ctrl #(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned FLUSH_BUBBLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             if_inst1_valid,
    input  logic             if_inst2_valid,
    input  logic [1:0]       id_slots,
    output logic             fetch_inst_1_en,
    output logic             fetch_inst_2_en,
    output logic             send_inst_1_en,
    output logic             send_inst_2_en,
    output logic             if_stall,
    output logic             send_valid_1,
    output logic             send_valid_2,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty,
    output logic             full,
    output logic [31:0]      stall_full_cnt,
    output logic [31:0]      empty_cnt
);

    localparam int unsigned BUB_W = 3;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [BUB_W-1:0]   bubble_q, bubble_d;
    logic               send_valid_1_q, send_valid_1_d;
    logic               send_valid_2_q, send_valid_2_d;

    logic [CNT_W-1:0]   free;
    logic [1:0]         accept;
    logic [1:0]         slots;
    logic [1:0]         n_send;

    assign free = DEPTH_C - occ_q;

    // Fetch acceptance: a pair is taken whole or not at all.
    always_comb begin
        accept = 2'd0;
        if (!rst && !flush && state_q != ST_FLUSH) begin
            if (if_inst1_valid && if_inst2_valid) begin
                if (free >= CNT_W'(2)) accept = 2'd2;
            end else if (if_inst1_valid) begin
                if (free >= CNT_W'(1)) accept = 2'd1;
            end
        end
    end

    // Issue count from entries already resident; same-cycle writes are not bypassed.
    always_comb begin
        slots  = (id_slots == 2'd3) ? 2'd2 : id_slots;
        n_send = 2'd0;
        if (!rst && !flush && !hold && state_q == ST_RUN) begin
            if (occ_q < CNT_W'(slots)) n_send = occ_q[1:0];
            else                       n_send = slots;
        end
    end

    assign fetch_inst_1_en = (accept != 2'd0);
    assign fetch_inst_2_en = (accept == 2'd2);
    assign send_inst_1_en  = (n_send != 2'd0);
    assign send_inst_2_en  = (n_send == 2'd2);
    assign if_stall        = flush || (state_q == ST_FLUSH) || (if_inst1_valid && accept == 2'd0);

    // Next-state, occupancy and bubble sequencing.
    always_comb begin
        state_d        = state_q;
        occ_d          = occ_q + CNT_W'(accept) - CNT_W'(n_send);
        bubble_d       = bubble_q;
        send_valid_1_d = send_inst_1_en;
        send_valid_2_d = send_inst_2_en;
        if (flush) begin
            state_d        = ST_FLUSH;
            occ_d          = '0;
            bubble_d       = BUB_W'(FLUSH_BUBBLE - 1);
            send_valid_1_d = 1'b0;
            send_valid_2_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_FLUSH: begin
                    if (bubble_q == '0) state_d = hold ? ST_HOLD : ST_RUN;
                    else                bubble_d = bubble_q - BUB_W'(1);
                end
                ST_RUN:  if (hold)  state_d = ST_HOLD;
                ST_HOLD: if (!hold) state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            occ_q          <= '0;
            bubble_q       <= '0;
            send_valid_1_q <= 1'b0;
            send_valid_2_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            occ_q          <= occ_d;
            bubble_q       <= bubble_d;
            send_valid_1_q <= send_valid_1_d;
            send_valid_2_q <= send_valid_2_d;
        end
    end

    assign send_valid_1 = send_valid_1_q;
    assign send_valid_2 = send_valid_2_q;
    assign occupancy    = occ_q;
    assign empty        = (occ_q == '0);
    assign full         = (occ_q == DEPTH_C);

`ifdef INSTBUF_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] empty_cnt_q, empty_cnt_d;

    // Saturating perf counters; flush does not clear them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        empty_cnt_d = empty_cnt_q;
        if (if_stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (state_q == ST_RUN && empty && empty_cnt_q != 32'hFFFF_FFFF)
            empty_cnt_d = empty_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            empty_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            empty_cnt_q <= empty_cnt_d;
        end
    end

    assign stall_full_cnt = stall_cnt_q;
    assign empty_cnt      = empty_cnt_q;
`else
    assign stall_full_cnt = 32'd0;
    assign empty_cnt      = 32'd0;
`endif

    // Protocol and occupancy guards.
    a_lone_inst2: assert property (@(posedge clk) disable iff (rst)
        !(if_inst2_valid && !if_inst1_valid && !flush && state_q != ST_FLUSH));
    a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ_q <= DEPTH_C);
    a_occ_under: assert property (@(posedge clk) disable iff (rst)
        CNT_W'(n_send) <= occ_q);

endmodule

// File: tb/tb_instbuffer_ctrl.sv
// Directed self-checking bench for instbuffer_ctrl (DEPTH=32, FLUSH_BUBBLE=2).
module tb_instbuffer_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush, hold, v1, v2;
    logic [1:0]  id_slots;
    logic        f1, f2, s1, s2, if_stall, sv1, sv2, empty, full;
    logic [5:0]  occupancy;
    logic [31:0] stall_full_cnt, empty_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    instbuffer_ctrl #(.DEPTH(32), .CNT_W(6), .FLUSH_BUBBLE(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold),
        .if_inst1_valid(v1), .if_inst2_valid(v2), .id_slots(id_slots),
        .fetch_inst_1_en(f1), .fetch_inst_2_en(f2),
        .send_inst_1_en(s1), .send_inst_2_en(s2), .if_stall(if_stall),
        .send_valid_1(sv1), .send_valid_2(sv2), .occupancy(occupancy),
        .empty(empty), .full(full),
        .stall_full_cnt(stall_full_cnt), .empty_cnt(empty_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a1, input logic a2, input logic [1:0] ids);
        v1 = a1; v2 = a2; id_slots = ids;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0; v1 = 1'b0; v2 = 1'b0; id_slots = 2'd0;
        tick();
        drive(1, 1, 2'd2);
        check("rst_fetch", {30'd0, f1, f2}, 32'd0);
        check("rst_send", {30'd0, s1, s2}, 32'd0);
        tick();
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_sv", {30'd0, sv1, sv2}, 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_perf", stall_full_cnt | empty_cnt, 32'd0);
        rst = 1'b0;

        // pair accepted, nothing sent
        drive(1, 1, 2'd0);
        check("t1_fetch", {30'd0, f1, f2}, 32'd3);
        check("t1_send", {30'd0, s1, s2}, 32'd0);
        tick();
        check("t1_occ", 32'(occupancy), 32'd2);

        // drain two
        drive(0, 0, 2'd2);
        check("t2_send", {30'd0, s1, s2}, 32'd3);
        tick();
        check("t2_occ", 32'(occupancy), 32'd0);
        check("t2_sv", {30'd0, sv1, sv2}, 32'd3);
        check("t2_empty", 32'(empty), 32'd1);
        drive(0, 0, 2'd0);
        tick();
        check("t2_sv_idle", {30'd0, sv1, sv2}, 32'd0);

        // fill to 31
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 2'd0);
            tick();
        end
        drive(1, 0, 2'd0);
        tick();
        check("t3_occ31", 32'(occupancy), 32'd31);
        drive(1, 1, 2'd0);
        check("t3_pair_refused", {30'd0, f1, f2}, 32'd0);
        check("t3_pair_stall", 32'(if_stall), 32'd1);
        drive(1, 0, 2'd0);
        check("t3_single_fetch", {30'd0, f1, f2}, 32'd2);
        check("t3_single_nostall", 32'(if_stall), 32'd0);
        tick();
        check("t3_occ32", 32'(occupancy), 32'd32);
        check("t3_full", 32'(full), 32'd1);
        drive(1, 0, 2'd0);
        check("t3_full_single_refused", {30'd0, f1, f2, if_stall}, 32'd1);
        // full with simultaneous send: pair still refused
        drive(1, 1, 2'd2);
        check("t3_full_send_fetch", {30'd0, f1, f2}, 32'd0);
        check("t3_full_send_en", {30'd0, s1, s2}, 32'd3);
        check("t3_full_send_stall", 32'(if_stall), 32'd1);
        tick();
        check("t3_occ30", 32'(occupancy), 32'd30);

        // drain to 10, then flush
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 2'd2);
            tick();
        end
        check("t4_occ10", 32'(occupancy), 32'd10);
        flush = 1'b1;
        drive(1, 1, 2'd2);
        check("t4_flush_en", {28'd0, f1, f2, s1, s2}, 32'd0);
        check("t4_flush_stall", 32'(if_stall), 32'd1);
        tick();
        flush = 1'b0;
        check("t4_occ0", 32'(occupancy), 32'd0);
        check("t4_sv0", {30'd0, sv1, sv2}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 2'd2);
            check("t4_bubble_stall", 32'(if_stall), 32'd1);
            check("t4_bubble_en", {28'd0, f1, f2, s1, s2}, 32'd0);
            tick();
        end
        drive(1, 1, 2'd2);
        check("t4_resume_fetch", {30'd0, f1, f2}, 32'd3);
        check("t4_resume_stall", 32'(if_stall), 32'd0);
        check("t4_resume_nosend", {30'd0, s1, s2}, 32'd0);
        tick();
        check("t4_occ2", 32'(occupancy), 32'd2);

        // occupancy 5, then hold for three cycles
        drive(1, 1, 2'd0);
        tick();
        drive(1, 0, 2'd0);
        tick();
        check("t5_occ5", 32'(occupancy), 32'd5);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 2'd2);
            check("t5_hold_nosend", {30'd0, s1, s2}, 32'd0);
            check("t5_hold_fetch", 32'(f1), 32'd1);
            tick();
        end
        check("t5_occ8", 32'(occupancy), 32'd8);
        hold = 1'b0;
        drive(0, 0, 2'd2);
        check("t5_release_nosend", {30'd0, s1, s2}, 32'd0);
        tick();
        drive(0, 0, 2'd3);
        check("t5_resume_send", {30'd0, s1, s2}, 32'd3);
        tick();
        check("t5_occ6", 32'(occupancy), 32'd6);
        check("t5_sv", {30'd0, sv1, sv2}, 32'd3);
        drive(0, 0, 2'd1);
        check("t5_one_slot", {30'd0, s1, s2}, 32'd2);
        tick();
        check("t5_occ5b", 32'(occupancy), 32'd5);
        check("t5_sv_one", {30'd0, sv1, sv2}, 32'd2);

        // perf counters from a fresh reset
        rst = 1'b1;
        drive(0, 0, 2'd0);
        tick();
        rst = 1'b0;
        flush = 1'b1;
        tick();          // RUN+flush: stall, empty
        tick();          // FLUSH with flush held: stall
        flush = 1'b0;
        tick();          // bubble 1: stall
        tick();          // bubble 0: stall
        tick();          // RUN empty
        tick();          // RUN empty
`ifdef INSTBUF_PERF_CNT_EN
        check("p_stall4", stall_full_cnt, 32'd4);
        check("p_empty3", empty_cnt, 32'd3);
`else
        check("p_stall_off", stall_full_cnt, 32'd0);
        check("p_empty_off", empty_cnt, 32'd0);
`endif
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
`ifdef INSTBUF_PERF_CNT_EN
        check("p_stall_after_flush", stall_full_cnt, 32'd7);
        check("p_empty_after_flush", empty_cnt, 32'd4);
`else
        check("p_stall_off2", stall_full_cnt, 32'd0);
        check("p_empty_off2", empty_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
